// File: rtl/sr_pkg.sv
// Shared types and default constants for the SR latch pulse driver.
package sr_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SET_PULSE,
    RESET_PULSE,
    GAP
  } sr_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_PULSE_CYCLES    = 2;
  localparam int unsigned DEF_GAP_CYCLES      = 1;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
// rise is combinational: it is high in the cycle before the edge on which
// the debounced level goes 0->1, so the parent can latch it on that edge.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic rise
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          toggle;

  assign toggle = (sync_2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = toggle && sync_2;

  // Synchronize the raw request, then count consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= req;
      sync_2 <= sync_1;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (toggle) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_pulse_driver.sv
// Sequencer producing non-overlapping active-low pulses for a NAND SR latch.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   INIT        | after reset; launches the initial (un-acked) reset pulse
//   IDLE        | waiting for a pending set/reset request
//   SET_PULSE   | s_n driven low for PULSE_CYCLES cycles
//   RESET_PULSE | r_n driven low for PULSE_CYCLES cycles
//   GAP         | both drives high for GAP_CYCLES cycles
//
// All outputs are flops loaded from the decode of the current state, so the
// visible drive window trails the state register by one cycle.
module sr_pulse_driver
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic rst_req,
  output logic s_n,
  output logic r_n,
  output logic busy,
  output logic ack,
  output logic conflict,
  output logic q_model
);

  localparam int unsigned PW = cnt_width(PULSE_CYCLES);
  localparam int unsigned GW = cnt_width(GAP_CYCLES);

  sr_state_e     state, state_nxt;
  logic [PW-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic          set_rise, rst_rise;
  logic          set_pend, rst_pend;
  logic          set_clr, rst_clr;
  logic          req_seq, req_seq_nxt;
  logic          ack_due, ack_due_nxt;
  logic          s_n_d, r_n_d, busy_d, conflict_d;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (set_req),
    .rise (set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (rst_req),
    .rise (rst_rise)
  );

  // State register, down-counters, one-deep pending flags and sequence flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
      set_pend  <= 1'b0;
      rst_pend  <= 1'b0;
      req_seq   <= 1'b0;
      ack_due   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      set_pend  <= (set_pend && !set_clr) || set_rise;
      rst_pend  <= (rst_pend && !rst_clr) || rst_rise;
      req_seq   <= req_seq_nxt;
      ack_due   <= ack_due_nxt;
    end
  end

  // Next-state, counter and output decode; counters stop at zero.
  always_comb begin
    state_nxt     = state;
    pulse_cnt_nxt = pulse_cnt;
    gap_cnt_nxt   = gap_cnt;
    set_clr       = 1'b0;
    rst_clr       = 1'b0;
    req_seq_nxt   = req_seq;
    ack_due_nxt   = 1'b0;
    s_n_d         = 1'b1;
    r_n_d         = 1'b1;
    busy_d        = 1'b1;
    conflict_d    = 1'b0;
    case (state)
      INIT: begin
        state_nxt     = RESET_PULSE;
        pulse_cnt_nxt = PW'(PULSE_CYCLES - 1);
        req_seq_nxt   = 1'b0;
      end
      IDLE: begin
        busy_d = 1'b0;
        if (set_pend && rst_pend) begin
          set_clr    = 1'b1;
          rst_clr    = 1'b1;
          conflict_d = 1'b1;
        end else if (set_pend) begin
          set_clr       = 1'b1;
          state_nxt     = SET_PULSE;
          pulse_cnt_nxt = PW'(PULSE_CYCLES - 1);
          req_seq_nxt   = 1'b1;
        end else if (rst_pend) begin
          rst_clr       = 1'b1;
          state_nxt     = RESET_PULSE;
          pulse_cnt_nxt = PW'(PULSE_CYCLES - 1);
          req_seq_nxt   = 1'b1;
        end
      end
      SET_PULSE, RESET_PULSE: begin
        if (state == SET_PULSE) s_n_d = 1'b0;
        else                    r_n_d = 1'b0;
        if (pulse_cnt == '0) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GW'(GAP_CYCLES - 1);
        end else begin
          pulse_cnt_nxt = pulse_cnt - PW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt   = IDLE;
          ack_due_nxt = req_seq;
          req_seq_nxt = 1'b0;
        end else begin
          gap_cnt_nxt = gap_cnt - GW'(1);
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // Registered outputs; q_model tracks the latch from the drives issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_n      <= 1'b1;
      r_n      <= 1'b1;
      busy     <= 1'b0;
      ack      <= 1'b0;
      conflict <= 1'b0;
      q_model  <= 1'b0;
    end else begin
      s_n      <= s_n_d;
      r_n      <= r_n_d;
      busy     <= busy_d;
      ack      <= ack_due;
      conflict <= conflict_d;
      if (!s_n_d)      q_model <= 1'b1;
      else if (!r_n_d) q_model <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver with default parameters (D=4, P=2, G=1).
// Each step drives inputs just after a rising edge, then checks the outputs
// 1 time unit after the following rising edge.
module tb_sr_pulse_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic set_req;
  logic rst_req;
  logic s_n, r_n, busy, ack, conflict, q_model;

  int checks = 0;
  int errors = 0;
  int step   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic  rn, sr, rr;
    logic  s, r, b, a, c, q;
    string tag;
  } vec_t;

  vec_t tbl[$];

  sr_pulse_driver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (set_req),
    .rst_req (rst_req),
    .s_n     (s_n),
    .r_n     (r_n),
    .busy    (busy),
    .ack     (ack),
    .conflict(conflict),
    .q_model (q_model)
  );

  always #5 clk = ~clk;

  // Both latch drives low together would force the latch into its illegal state.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!s_n && !r_n) begin
        errors++;
        $display("FAIL both_low step %0d: s_n=%b r_n=%b, required not both 0", step, s_n, r_n);
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    end
  endtask

  task automatic apply(input logic rn, sr, rr, input logic es, er, eb, ea, ec, eq,
                       input string tag);
    rst_n   = rn;
    set_req = sr;
    rst_req = rr;
    @(posedge clk);
    #1;
    step++;
    chk({tag, ".s_n"},      s_n,      es);
    chk({tag, ".r_n"},      r_n,      er);
    chk({tag, ".busy"},     busy,     eb);
    chk({tag, ".ack"},      ack,      ea);
    chk({tag, ".conflict"}, conflict, ec);
    chk({tag, ".q_model"},  q_model,  eq);
    mon_en = 1'b1;
  endtask

  function automatic void add(input int n, input logic rn, sr, rr,
                              input logic s, r, b, a, c, q, input string tag);
    vec_t v;
    v.rn = rn; v.sr = sr; v.rr = rr;
    v.s = s; v.r = r; v.b = b; v.a = a; v.c = c; v.q = q;
    v.tag = tag;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  initial begin
    rst_n   = 1'b0;
    set_req = 1'b0;
    rst_req = 1'b0;

    // Reset, then the initial un-acked reset pulse.
    add(2,  0, 0, 0,  1, 1, 0, 0, 0, 0, "reset");
    add(1,  1, 0, 0,  1, 1, 1, 0, 0, 0, "init");
    add(2,  1, 0, 0,  1, 0, 1, 0, 0, 0, "init_pulse");
    add(1,  1, 0, 0,  1, 1, 1, 0, 0, 0, "init_gap");
    add(3,  1, 0, 0,  1, 1, 0, 0, 0, 0, "init_idle");
    // Clean set request held 12 cycles: pulse after edge 7.
    add(7,  1, 1, 0,  1, 1, 0, 0, 0, 0, "set_wait");
    add(2,  1, 1, 0,  0, 1, 1, 0, 0, 1, "set_pulse");
    add(1,  1, 1, 0,  1, 1, 1, 0, 0, 1, "set_gap");
    add(1,  1, 1, 0,  1, 1, 0, 1, 0, 1, "set_ack");
    add(1,  1, 1, 0,  1, 1, 0, 0, 0, 1, "set_after");
    add(8,  1, 0, 0,  1, 1, 0, 0, 0, 1, "set_release");
    // Request one cycle too short to pass the debouncer.
    add(3,  1, 1, 0,  1, 1, 0, 0, 0, 1, "short_hi");
    add(10, 1, 0, 0,  1, 1, 0, 0, 0, 1, "short_lo");
    // Simultaneous set and reset requests.
    add(6,  1, 1, 1,  1, 1, 0, 0, 0, 1, "both_wait");
    add(1,  1, 1, 1,  1, 1, 0, 0, 1, 1, "both_conflict");
    add(3,  1, 1, 1,  1, 1, 0, 0, 0, 1, "both_hold");
    add(10, 1, 0, 0,  1, 1, 0, 0, 0, 1, "both_release");

    foreach (tbl[i])
      apply(tbl[i].rn, tbl[i].sr, tbl[i].rr, tbl[i].s, tbl[i].r, tbl[i].b,
            tbl[i].a, tbl[i].c, tbl[i].q, tbl[i].tag);

    // Reset request rising during a set pulse: queued and served afterwards.
    for (int k = 0; k < 24; k++) begin
      apply(1'b1, k < 8, (k >= 7) && (k < 15),
            !(k == 7 || k == 8),
            !(k == 14 || k == 15),
            (k >= 7 && k <= 9) || (k >= 14 && k <= 16),
            (k == 10) || (k == 17),
            1'b0,
            k < 14,
            "set_then_reset");
    end

    // Reset mid set pulse with a reset request already pending: the pending
    // request must be dropped, and only the initial reset pulse follows.
    for (int k = 0; k < 22; k++) begin
      apply(!(k == 8 || k == 9), k < 8, (k >= 2) && (k < 8),
            k != 7,
            !(k == 11 || k == 12),
            (k == 7) || (k >= 10 && k <= 13),
            1'b0,
            1'b0,
            k == 7,
            "reset_mid_pulse");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
